// File: rtl/dram_refresh_arbiter.sv
// DRAM sequencer for the FastRAM card: arbitrates 68000 accesses against timer-driven CBR refresh.
// Optional REFRESH_BURST_EN drains the refresh backlog back-to-back without returning to IDLE.
module dram_refresh_arbiter #(
  parameter int REFRESH_INTERVAL = 108,
  parameter int MAX_PENDING      = 8,
  parameter int REF_RAS_CYCLES   = 2,
  parameter int PRECHARGE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ram_cycle,
  input  logic       ASn,
  input  logic       UDSn,
  input  logic       LDSn,
  input  logic       RWn,
  output logic       RASn,
  output logic       UCASn,
  output logic       LCASn,
  output logic       OEn,
  output logic       mux_col,
  output logic       busy,
  output logic [3:0] ref_pending,
  output logic       ref_overrun
);

  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int CW = $clog2(REF_RAS_CYCLES + PRECHARGE_CYCLES + 1);
  localparam logic [3:0] PMAX = 4'(MAX_PENDING);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_ROW = 3'd1,
    ACC_COL = 3'd2,
    ACC_CAS = 3'd3,
    REF_CAS = 3'd4,
    REF_RAS = 3'd5,
    PRE     = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [TW-1:0]   timer_r;
  logic [CW-1:0]   cnt_r;
  logic            after_ref_r;
  logic            tick_s;
  logic            start_s;

  assign tick_s = (timer_r == TW'(REFRESH_INTERVAL - 1));

  // Next-state selection; start_s marks the cycle a refresh consumes a pending slot.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ram_cycle) begin
          state_s = ACC_ROW;
        end else if ((ref_pending != 4'd0) && ASn) begin
          state_s = REF_CAS;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACC_ROW: begin
        if (ASn) state_s = PRE;
        else     state_s = ACC_COL;
      end
      ACC_COL: begin
        if (ASn) state_s = PRE;
        else     state_s = ACC_CAS;
      end
      ACC_CAS: begin
        if (ASn) state_s = PRE;
        else     state_s = ACC_CAS;
      end
      REF_CAS: state_s = REF_RAS;
      REF_RAS: begin
        if (cnt_r == CW'(REF_RAS_CYCLES - 1)) state_s = PRE;
        else                                  state_s = REF_RAS;
      end
      PRE: begin
        if (cnt_r == CW'(PRECHARGE_CYCLES - 1)) begin
`ifdef REFRESH_BURST_EN
          if (after_ref_r && (ref_pending != 4'd0) && !ram_cycle && ASn) begin
            state_s = REF_CAS;
            start_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = PRE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, refresh bookkeeping and Moore outputs decoded from the state being entered.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      timer_r     <= TW'(0);
      cnt_r       <= CW'(0);
      after_ref_r <= 1'b0;
      ref_pending <= 4'd0;
      ref_overrun <= 1'b0;
      RASn        <= 1'b1;
      UCASn       <= 1'b1;
      LCASn       <= 1'b1;
      OEn         <= 1'b1;
      mux_col     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= tick_s ? TW'(0) : timer_r + TW'(1);
      cnt_r   <= (state_s == state_r) ? cnt_r + CW'(1) : CW'(0);

      if (tick_s && (ref_pending == PMAX)) ref_overrun <= 1'b1;

      // Simultaneous tick and refresh start cancel out.
      if (tick_s && !start_s) begin
        if (ref_pending != PMAX) ref_pending <= ref_pending + 4'd1;
      end else if (start_s && !tick_s) begin
        ref_pending <= ref_pending - 4'd1;
      end

      if (state_s == REF_CAS)      after_ref_r <= 1'b1;
      else if (state_s == ACC_ROW) after_ref_r <= 1'b0;

      busy <= (state_s != IDLE);
      case (state_s)
        ACC_ROW: begin
          RASn <= 1'b0; UCASn <= 1'b1; LCASn <= 1'b1; OEn <= 1'b1; mux_col <= 1'b0;
        end
        ACC_COL: begin
          RASn <= 1'b0; UCASn <= 1'b1; LCASn <= 1'b1; OEn <= 1'b1; mux_col <= 1'b1;
        end
        ACC_CAS: begin
          RASn <= 1'b0; UCASn <= UDSn; LCASn <= LDSn; OEn <= ~RWn; mux_col <= 1'b1;
        end
        REF_CAS: begin
          RASn <= 1'b1; UCASn <= 1'b0; LCASn <= 1'b0; OEn <= 1'b1; mux_col <= 1'b0;
        end
        REF_RAS: begin
          RASn <= 1'b0; UCASn <= 1'b0; LCASn <= 1'b0; OEn <= 1'b1; mux_col <= 1'b0;
        end
        default: begin
          RASn <= 1'b1; UCASn <= 1'b1; LCASn <= 1'b1; OEn <= 1'b1; mux_col <= 1'b0;
        end
      endcase
    end
  end

endmodule
